// File: rtl/branch_sequencer.sv
// branch_sequencer: owns the fetch PC, predicts conditional branches in IF
// with a table of 2-bit saturating counters, and repairs fetch when the EX
// stage resolves a branch differently from the prediction it carried.
module branch_sequencer #(
    parameter int unsigned INDEX_BITS = 6,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // IF stage
    input  logic                  stallIF,
    input  logic                  ifIsBranch,
    input  logic [31:0]           ifTarget,
    output logic [31:0]           fetchPC,
    output logic                  predTaken,
    // EX stage
    input  logic                  exValid,
    input  logic                  exIsBranch,
    input  logic [31:0]           exPC,
    input  logic                  exTaken,
    input  logic [31:0]           exBranchAddr,
    input  logic                  exPredTaken,
    output logic                  flush,
    // statistics
    output logic [STAT_WIDTH-1:0] statBranches,
    output logic [STAT_WIDTH-1:0] statMispredict
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    // 2-bit counter encodings; bit 1 is the taken/not-taken prediction.
    localparam logic [1:0] CNT_STRONG_NT = 2'b00;
    localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
    localparam logic [1:0] CNT_STRONG_T  = 2'b11;

    localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    // Branch history table, held in flops so every entry clears on reset.
    logic [1:0] bht [ENTRIES];

    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] train_idx;
    logic [1:0]            train_cur;
    logic [1:0]            train_next;
    logic                  resolve;
    logic                  mispredict;
    logic [31:0]           redirect;
    logic [31:0]           next_pc;

    assign pred_idx  = fetchPC[INDEX_BITS+1:2];
    assign train_idx = exPC[INDEX_BITS+1:2];

    // Prediction is a plain read of the current table contents; a training
    // write to the same entry in this cycle is not forwarded.
    assign predTaken = ifIsBranch & bht[pred_idx][1];

    assign resolve    = exValid & exIsBranch;
    assign mispredict = resolve & (exTaken != exPredTaken);
    assign flush      = mispredict;
    assign redirect   = exTaken ? exBranchAddr : exPC + 32'd4;

    // Next fetch address: a mispredict repair beats a stall, which beats a
    // predicted-taken branch, which beats sequential fetch.
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else chain leaves it unassigned (which would infer a latch).
    always_comb begin
        next_pc = fetchPC + 32'd4;
        if (mispredict) begin
            next_pc = redirect;
        end else if (stallIF) begin
            next_pc = fetchPC;
        end else if (predTaken) begin
            next_pc = ifTarget;
        end
    end

    // Saturating update of the counter belonging to the resolving branch.
    always_comb begin
        train_cur  = bht[train_idx];
        train_next = train_cur;
        if (exTaken) begin
            if (train_cur != CNT_STRONG_T) begin
                train_next = train_cur + 2'd1;
            end
        end else begin
            if (train_cur != CNT_STRONG_NT) begin
                train_next = train_cur - 2'd1;
            end
        end
    end

    // Fetch PC register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPC <= RESET_PC;
        end else begin
            fetchPC <= next_pc;
        end
    end

    // Branch history table: cleared to weakly not-taken, trained on every resolve.
    // NOTE: this array is reset entry by entry, which forces it into flops; a
    // RAM macro has no reset and would keep stale history across rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                bht[i] <= CNT_WEAK_NT;
            end
        end else if (resolve) begin
            bht[train_idx] <= train_next;
        end
    end

    // Resolved-branch and misprediction counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statBranches   <= '0;
            statMispredict <= '0;
        end else begin
            if (resolve && statBranches != STAT_MAX) begin
                statBranches <= statBranches + STAT_ONE;
            end
            if (mispredict && statMispredict != STAT_MAX) begin
                statMispredict <= statMispredict + STAT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer. The driver applies one cycle of inputs
// at a time and queues the hand-computed outputs for that cycle; a monitor
// samples the DUT on the falling edge and compares against the queue head.
module tb_branch_sequencer;

    localparam int SW = 4;  // narrow statistics so saturation is quick to reach

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stallIF;
    logic          ifIsBranch;
    logic [31:0]   ifTarget;
    logic [31:0]   fetchPC;
    logic          predTaken;
    logic          exValid;
    logic          exIsBranch;
    logic [31:0]   exPC;
    logic          exTaken;
    logic [31:0]   exBranchAddr;
    logic          exPredTaken;
    logic          flush;
    logic [SW-1:0] statBranches;
    logic [SW-1:0] statMispredict;

    branch_sequencer #(
        .INDEX_BITS (6),
        .RESET_PC   (32'h0000_3000),
        .STAT_WIDTH (SW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stallIF        (stallIF),
        .ifIsBranch     (ifIsBranch),
        .ifTarget       (ifTarget),
        .fetchPC        (fetchPC),
        .predTaken      (predTaken),
        .exValid        (exValid),
        .exIsBranch     (exIsBranch),
        .exPC           (exPC),
        .exTaken        (exTaken),
        .exBranchAddr   (exBranchAddr),
        .exPredTaken    (exPredTaken),
        .flush          (flush),
        .statBranches   (statBranches),
        .statMispredict (statMispredict)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        pred;
        logic        fl;
        logic [SW-1:0] br;
        logic [SW-1:0] mp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, " fetchPC"},        fetchPC,               e.pc);
            check({e.tag, " predTaken"},      32'(predTaken),        32'(e.pred));
            check({e.tag, " flush"},          32'(flush),            32'(e.fl));
            check({e.tag, " statBranches"},   32'(statBranches),     32'(e.br));
            check({e.tag, " statMispredict"}, 32'(statMispredict),   32'(e.mp));
        end
    end

    function automatic int min15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic idle();
        stallIF      = 1'b0;
        ifIsBranch   = 1'b0;
        ifTarget     = 32'h0;
        exValid      = 1'b0;
        exIsBranch   = 1'b0;
        exPC         = 32'h0;
        exTaken      = 1'b0;
        exBranchAddr = 32'h0;
        exPredTaken  = 1'b0;
    endtask

    task automatic resolve_in(input logic [31:0] pc, input logic taken,
                              input logic [31:0] addr, input logic pred);
        exValid      = 1'b1;
        exIsBranch   = 1'b1;
        exPC         = pc;
        exTaken      = taken;
        exBranchAddr = addr;
        exPredTaken  = pred;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic pred,
                              input logic fl, input int br, input int mp);
        exp_t e;
        e.tag  = tag;
        e.pc   = pc;
        e.pred = pred;
        e.fl   = fl;
        e.br   = SW'(br);
        e.mp   = SW'(mp);
        exp_q.push_back(e);
    endtask

    task automatic step(input string tag, input logic [31:0] pc, input logic pred,
                        input logic fl, input int br, input int mp);
        expect_out(tag, pc, pred, fl, br, mp);
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        step("T1 reset a", 32'h3000, 0, 0, 0, 0);
        step("T1 reset b", 32'h3000, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Sequential fetch
        for (int i = 0; i < 4; i++) begin
            step("T2 seq", 32'h3000 + 32'(4 * i), 0, 0, 0, 0);
        end

        // Training of the branch at 0x3010 (index 4), counter starts at 01
        ifIsBranch = 1'b1; ifTarget = 32'h3100;
        step("T4 first fetch", 32'h3010, 0, 0, 0, 0);
        idle(); resolve_in(32'h3010, 1'b1, 32'h3100, 1'b0);
        step("T4 resolve1", 32'h3014, 0, 1, 0, 0);           // 01 -> 10, redirect 0x3100
        resolve_in(32'h3010, 1'b1, 32'h3100, 1'b1);
        step("T4 resolve2", 32'h3100, 0, 0, 1, 1);           // 10 -> 11
        step("T4 resolve3", 32'h3104, 0, 0, 2, 1);           // stays 11
        idle(); resolve_in(32'h300C, 1'b0, 32'hDEAD_BEEF, 1'b1);
        step("T4 redirect back", 32'h3108, 0, 1, 3, 1);      // not-taken -> 0x3010
        idle(); ifIsBranch = 1'b1; ifTarget = 32'h3200;
        step("T4 predict taken", 32'h3010, 1, 0, 4, 2);
        idle();
        step("T4 target fetched", 32'h3200, 0, 0, 4, 2);

        // Mispredict overrides stall
        stallIF = 1'b1; resolve_in(32'h3030, 1'b1, 32'h3040, 1'b0);
        step("T3 stall+mispredict", 32'h3204, 0, 1, 4, 2);
        idle(); stallIF = 1'b1;
        step("T3 redirected", 32'h3040, 0, 0, 5, 3);
        idle();
        step("T3 held", 32'h3040, 0, 0, 5, 3);

        // EX outcome ignored without a valid branch; ifTarget ignored without a branch
        exIsBranch = 1'b1; exTaken = 1'b1; exBranchAddr = 32'h9999; ifTarget = 32'h5555_0000;
        step("ign exValid0", 32'h3044, 0, 0, 5, 3);
        idle(); exValid = 1'b1; exTaken = 1'b1; exBranchAddr = 32'h9999;
        step("ign not branch", 32'h3048, 0, 0, 5, 3);

        // Not-taken mispredict on 0x3020 (index 8) after training to 11
        idle(); resolve_in(32'h3020, 1'b1, 32'h3060, 1'b1);
        step("T5 train1", 32'h304C, 0, 0, 5, 3);
        step("T5 train2", 32'h3050, 0, 0, 6, 3);
        idle(); resolve_in(32'h3020, 1'b0, 32'h3060, 1'b1);
        step("T5 mispredict NT", 32'h3054, 0, 1, 7, 3);      // 11 -> 10, redirect 0x3024

        // No bypass: fetch 0x3120 (index 8) while index 8 is trained down
        idle(); resolve_in(32'h3300, 1'b1, 32'h3120, 1'b0);
        step("T6 redirect", 32'h3024, 0, 1, 8, 4);
        idle(); ifIsBranch = 1'b1; ifTarget = 32'h3400; resolve_in(32'h3020, 1'b0, 32'h0, 1'b0);
        step("T6 no bypass", 32'h3120, 1, 0, 9, 5);          // old 10 predicts taken; 10 -> 01
        idle(); resolve_in(32'h3500, 1'b1, 32'h3120, 1'b0);
        step("T6 redirect2", 32'h3400, 0, 1, 10, 5);
        idle(); ifIsBranch = 1'b1; ifTarget = 32'h3400;
        step("T6 trained", 32'h3120, 0, 0, 11, 6);

        // Statistics saturate at 4'hF
        idle(); resolve_in(32'h3600, 1'b1, 32'h3700, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step("T6 stat sat", (k == 0) ? 32'h3124 : 32'h3700, 0, 1, min15(11 + k), min15(6 + k));
        end
        idle();
        step("T6 stat hold", 32'h3700, 0, 0, 15, 15);

        // 32-bit wrap of sequential fetch
        resolve_in(32'h3600, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step("wrap redirect", 32'h3704, 0, 1, 15, 15);
        idle();
        step("wrap top", 32'hFFFF_FFFC, 0, 0, 15, 15);
        step("wrap zero", 32'h0000_0000, 0, 0, 15, 15);

        // Reset mid-run with a redirect pending
        resolve_in(32'h3600, 1'b1, 32'h3700, 1'b0);
        expect_out("T1 pending flush", 32'h4, 0, 1, 15, 15);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step("T1 in reset", 32'h3000, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("T1 after reset", 32'h3000 + 32'(4 * i), 0, 0, 0, 0);
        end
        ifIsBranch = 1'b1; ifTarget = 32'h3100;
        step("T1 bht cleared", 32'h3010, 0, 0, 0, 0);
        idle();
        step("T1 done", 32'h3014, 0, 0, 0, 0);

        // Drain any outstanding expectations, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
